hdmi_pattern_timing: RTL and testbench
======================================

// Module: hdmi_pattern_timing
// PURPOSE
//  Parametrised video timing + test-pattern source for the ADV7513 parallel RGB input.
//  Generates h_sync/v_sync/data_enable for any CEA/VESA mode given by parameters.
//  Drives four selectable patterns (solid switch colour, 8 colour bars, checkerboard, XY gradient).
//  Sits between the pixel-clock PLL and the HDMI_TX_* pins; the I2C configuration block is unchanged.
// PARAMETERS
//  H_ACTIVE    640  visible pixels per line; must be a multiple of 8
//  H_FP        16   horizontal front porch, pixels
//  H_SYNC      96   horizontal sync width, pixels
//  H_BP        48   horizontal back porch, pixels
//  V_ACTIVE    480  visible lines per frame
//  V_FP        10   vertical front porch, lines
//  V_SYNC      2    vertical sync width, lines
//  V_BP        33   vertical back porch, lines
//  HS_POL      0    h_sync active level (0 = active-low)
//  VS_POL      0    v_sync active level (0 = active-low)
//  COLOR_W     8    bits per colour channel
//  CHECK_LOG2  5    checker square edge = 2**CHECK_LOG2 pixels
// PORTS
//  clock        in   1          pixel clock; all logic on the rising edge
//  reset_n      in   1          asynchronous assert, active-low
//  mode         in   2          pattern select: 0 solid, 1 bars, 2 checker, 3 gradient (asynchronous)
//  switch_red   in   1          solid-mode red enable (asynchronous)
//  switch_green in   1          solid-mode green enable (asynchronous)
//  switch_blue  in   1          solid-mode blue enable (asynchronous)
//  h_sync       out  1          horizontal sync, polarity set by HS_POL
//  v_sync       out  1          vertical sync, polarity set by VS_POL
//  data_enable  out  1          high during the active pixel region only
//  rgb_channel  out  3*COLOR_W  {R,G,B}; zero whenever data_enable is low
//  frame_start  out  1          one-cycle pulse aligned with the first active pixel of each frame
// BEHAVIOUR
//  - Reset: h_cnt=v_cnt=0; h_sync=~HS_POL, v_sync=~VS_POL, data_enable=0, rgb_channel=0, frame_start=0.
//    Mode and switch latches clear to 0 (solid black). Reset mid-line aborts immediately; no partial-frame recovery.
//  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h_cnt 0..H_TOTAL-1 wraps to 0.
//    v_cnt increments when h_cnt wraps, and wraps to 0 after V_TOTAL-1.
//    Counter width = $clog2(total).
//  - Regions along h_cnt: active [0,H_ACTIVE), FP, sync [H_ACTIVE+H_FP, +H_SYNC), BP. v_cnt regions are the same form.
//  - Latency: every output is registered from the counter state, 1 clock after it; all outputs mutually aligned.
//  - data_enable = h_active & v_active. h_sync asserts in the h-sync region on every line, including vertical blanking.
//  - frame_start is high for the output cycle of h_cnt=0, v_cnt=0.
//  - Async inputs: mode and switch_* each pass through a 2-flop synchroniser.
//    Synchronised values are latched into mode_q/sw_q only on h_cnt=H_TOTAL-1 & v_cnt=V_TOTAL-1.
//    A mid-frame change therefore never tears; it takes effect at the next frame.
//  - Pattern (x=h_cnt, y=v_cnt in the active region; F = all ones of COLOR_W):
//      0 solid:    each channel = F if its latched switch is set, else 0.
//      1 bars:     bar index 0..7 is advanced by a sub-counter every H_ACTIVE/8 pixels and cleared at h_cnt=0 (no divider).
//                  Colours in order: white, yellow, cyan, green, magenta, red, blue, black.
//      2 checker:  white if x[CHECK_LOG2]^y[CHECK_LOG2], else black.
//      3 gradient: R=x[COLOR_W-1:0], G=y[COLOR_W-1:0], B=R^G (wraps naturally).
// STRUCTURE
//  - Package hdmi_video_pkg: pattern-mode enum, 8-entry bar colour table, 640x480@60 timing constants.
//  - One sub-module, hdmi_sync_counter: h/v counters, region decode and frame-boundary strobe.
//  - Pattern mux, input synchronisers and output registers stay in this module.
// TESTING
//  1 Reset: hold reset_n=0 for 5 clocks -> h_sync=v_sync=1, data_enable=0, rgb_channel=0 (defaults).
//  2 Timing: 2 full frames at defaults -> 800 clocks between h_sync falls; 96-clock low pulse.
//    525 lines per frame; v_sync low exactly 2 lines; data_enable high 640x480 per frame.
//  3 Solid: switch_red=1, switch_green=0, switch_blue=1, mode=0 -> next frame rgb_channel=24'hFF00FF on all active pixels.
//  4 Bars: mode=1 -> pixels 0..79 = 24'hFFFFFF, 80..159 = 24'hFFFF00, 560..639 = 24'h000000.
//  5 Mid-frame mode change at line 200: mode 0->2 -> current frame stays solid.
//    Next frame x=32,y=0 is white, x=0,y=0 is black; frame_start pulses once per 420000 clocks.
//  6 Parameter sweep: HS_POL=1, VS_POL=1, 1280x720 CEA timings, mode=3 -> sync pulses active-high.
//    Pixel x=300,y=5 gives rgb_channel=24'h2C0529.

Source files
------------

// File: rtl/hdmi_video_pkg.sv
// Shared video types, colour-bar table and default 640x480@60 timing for the
// HDMI test-pattern source.
package hdmi_video_pkg;

    typedef enum logic [1:0] {
        PAT_SOLID    = 2'd0,
        PAT_BARS     = 2'd1,
        PAT_CHECKER  = 2'd2,
        PAT_GRADIENT = 2'd3
    } pattern_mode_t;

    // {R,G,B} full-scale enables per bar, left to right
    localparam logic [2:0] BAR_RGB [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hdmi_sync_counter.sv
// Horizontal/vertical raster counters with region decode and frame-boundary
// strobes; all decode outputs are combinational from the counter state.
module hdmi_sync_counter
    import hdmi_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter int unsigned HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int unsigned VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clock,
    input  logic          reset_n,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          h_active,
    output logic          v_active,
    output logic          h_sync_on,
    output logic          v_sync_on,
    output logic          h_last,
    output logic          frame_first,
    output logic          frame_last
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic v_last;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        h_last      = (h_cnt == H_LAST);
        v_last      = (v_cnt == V_LAST);
        h_active    = (h_cnt < H_ACT_END);
        v_active    = (v_cnt < V_ACT_END);
        h_sync_on   = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        v_sync_on   = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
        frame_first = (h_cnt == '0) && (v_cnt == '0);
        frame_last  = h_last && v_last;
    end

endmodule

// File: rtl/hdmi_pattern_timing.sv
// Video timing and test-pattern source for the ADV7513 parallel RGB input:
// sync generation, four selectable patterns, frame-aligned control latching.
module hdmi_pattern_timing
    import hdmi_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
    parameter int unsigned H_FP       = VGA_H_FP,
    parameter int unsigned H_SYNC     = VGA_H_SYNC,
    parameter int unsigned H_BP       = VGA_H_BP,
    parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
    parameter int unsigned V_FP       = VGA_V_FP,
    parameter int unsigned V_SYNC     = VGA_V_SYNC,
    parameter int unsigned V_BP       = VGA_V_BP,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int unsigned COLOR_W    = 8,
    parameter int unsigned CHECK_LOG2 = 5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [1:0]           mode,
    input  logic                 switch_red,
    input  logic                 switch_green,
    input  logic                 switch_blue,
    output logic                 h_sync,
    output logic                 v_sync,
    output logic                 data_enable,
    output logic [3*COLOR_W-1:0] rgb_channel,
    output logic                 frame_start
);

    localparam int unsigned HW    = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int unsigned VW    = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int unsigned PW    = max_u(max_u(HW, VW), max_u(CHECK_LOG2 + 1, COLOR_W));
    localparam int unsigned BAR_W = H_ACTIVE / 8;
    localparam int unsigned BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_active, v_active, h_sync_on, v_sync_on;
    logic          h_last, frame_first, frame_last;

    hdmi_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_sync_counter (
        .clock       (clock),
        .reset_n     (reset_n),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .h_active    (h_active),
        .v_active    (v_active),
        .h_sync_on   (h_sync_on),
        .v_sync_on   (v_sync_on),
        .h_last      (h_last),
        .frame_first (frame_first),
        .frame_last  (frame_last)
    );

    // {mode[1:0], red, green, blue} through a two-flop synchroniser
    logic [4:0]    in_meta, in_sync;
    pattern_mode_t mode_q;
    logic [2:0]    sw_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_meta <= '0;
            in_sync <= '0;
            mode_q  <= PAT_SOLID;
            sw_q    <= '0;
        end else begin
            in_meta <= {mode, switch_red, switch_green, switch_blue};
            in_sync <= in_meta;
            if (frame_last) begin
                mode_q <= pattern_mode_t'(in_sync[4:3]);
                sw_q   <= in_sync[2:0];
            end
        end
    end

    // Bar index tracks h_cnt without a divider; it free-runs through blanking,
    // where the output is masked anyway.
    logic [BW-1:0] bar_cnt;
    logic [2:0]    bar_idx;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (h_last) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (bar_cnt == BAR_LAST) begin
            bar_cnt <= '0;
            bar_idx <= bar_idx + 1'b1;
        end else begin
            bar_cnt <= bar_cnt + 1'b1;
        end
    end

    logic [PW-1:0]        x, y;
    logic [COLOR_W-1:0]   gx, gy;
    logic [2:0]           bar_en;
    logic [3*COLOR_W-1:0] pixel;

    always_comb begin
        x      = PW'(h_cnt);
        y      = PW'(v_cnt);
        gx     = COLOR_W'(x);
        gy     = COLOR_W'(y);
        bar_en = BAR_RGB[bar_idx];
        pixel  = '0;
        unique case (mode_q)
            PAT_SOLID:    pixel = {{COLOR_W{sw_q[2]}}, {COLOR_W{sw_q[1]}}, {COLOR_W{sw_q[0]}}};
            PAT_BARS:     pixel = {{COLOR_W{bar_en[2]}}, {COLOR_W{bar_en[1]}}, {COLOR_W{bar_en[0]}}};
            PAT_CHECKER:  pixel = {(3*COLOR_W){x[CHECK_LOG2] ^ y[CHECK_LOG2]}};
            PAT_GRADIENT: pixel = {gx, gy, gx ^ gy};
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_sync      <= ~HS_POL;
            v_sync      <= ~VS_POL;
            data_enable <= 1'b0;
            rgb_channel <= '0;
            frame_start <= 1'b0;
        end else begin
            h_sync      <= h_sync_on ? HS_POL : ~HS_POL;
            v_sync      <= v_sync_on ? VS_POL : ~VS_POL;
            data_enable <= h_active & v_active;
            rgb_channel <= (h_active & v_active) ? pixel : '0;
            frame_start <= frame_first;
        end
    end

endmodule

// File: tb/tb_hdmi_pattern_timing.sv
// Directed bench: default 640x480 instance for reset/line timing, a shrunken
// raster for frame-level pattern tests, and a 1280-wide active-high instance.
`timescale 1ns/1ps
module tb_hdmi_pattern_timing;

    localparam int SH_ACT   = 64;
    localparam int SH_TOT   = 80;
    localparam int SV_ACT   = 32;
    localparam int SV_TOT   = 39;
    localparam int S_FRAME  = SH_TOT * SV_TOT;
    localparam int HD_H_TOT = 1650;
    localparam int HD_V_TOT = 9;
    localparam int HD_FRAME = HD_H_TOT * HD_V_TOT;
    localparam int K_SOLID  = 0;
    localparam int K_BARS   = 1;
    localparam int K_CHECK  = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic [1:0]  mode_s, mode_d, mode_h;
    logic        red_s, green_s, blue_s, red_d, green_d, blue_d, red_h, green_h, blue_h;
    logic        hs_s, vs_s, de_s, fs_s, hs_d, vs_d, de_d, fs_d, hs_h, vs_h, de_h, fs_h;
    logic [23:0] rgb_s, rgb_d, rgb_h;

    hdmi_pattern_timing #(
        .H_ACTIVE (64), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_ACTIVE (32), .V_FP (2), .V_SYNC (2), .V_BP (3)
    ) u_small (
        .clock (clock), .reset_n (reset_n), .mode (mode_s),
        .switch_red (red_s), .switch_green (green_s), .switch_blue (blue_s),
        .h_sync (hs_s), .v_sync (vs_s), .data_enable (de_s),
        .rgb_channel (rgb_s), .frame_start (fs_s)
    );

    hdmi_pattern_timing u_def (
        .clock (clock), .reset_n (reset_n), .mode (mode_d),
        .switch_red (red_d), .switch_green (green_d), .switch_blue (blue_d),
        .h_sync (hs_d), .v_sync (vs_d), .data_enable (de_d),
        .rgb_channel (rgb_d), .frame_start (fs_d)
    );

    hdmi_pattern_timing #(
        .H_ACTIVE (1280), .H_FP (110), .H_SYNC (40), .H_BP (220),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL (1'b1), .VS_POL (1'b1)
    ) u_hd (
        .clock (clock), .reset_n (reset_n), .mode (mode_h),
        .switch_red (red_h), .switch_green (green_h), .switch_blue (blue_h),
        .h_sync (hs_h), .v_sync (vs_h), .data_enable (de_h),
        .rgb_channel (rgb_h), .frame_start (fs_h)
    );

    int checks = 0;
    int errors = 0;
    logic [23:0] pix [SV_ACT][SH_ACT];
    int de_bad, blank_bad, fs_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return hs_d;
            1:       return hs_s;
            2:       return vs_s;
            3:       return fs_s;
            4:       return fs_h;
            default: return de_s;
        endcase
    endfunction

    // Counts negedge samples until sig(sel) moves to lvl; -1 when budget runs out
    task automatic wait_edge(input int sel, input logic lvl, input int budget, output int n);
        logic prev, cur;
        bit   hit;
        prev = sig(sel);
        n    = 0;
        hit  = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clock);
            n++;
            cur = sig(sel);
            if (prev !== lvl && cur === lvl) hit = 1'b1;
            prev = cur;
        end
        if (!hit) n = -1;
    endtask

    task automatic capture_small(input int change_at, input logic [1:0] new_mode);
        int n, x, y;
        wait_edge(3, 1'b1, S_FRAME + 10, n);
        check("fs_wait", n > 0, 1'b1);
        de_bad    = 0;
        blank_bad = 0;
        fs_seen   = 0;
        for (int i = 0; i < S_FRAME; i++) begin
            if (i > 0) @(negedge clock);
            if (i == change_at) mode_s = new_mode;
            x = i % SH_TOT;
            y = i / SH_TOT;
            if (fs_s) fs_seen++;
            if (x < SH_ACT && y < SV_ACT) begin
                pix[y][x] = rgb_s;
                if (!de_s) de_bad++;
            end else if (de_s || rgb_s != 24'h0) begin
                blank_bad++;
            end
        end
    endtask

    function automatic int count_bad(input int kind, input logic [23:0] solid);
        logic [23:0] bars [8];
        logic [23:0] e;
        int bad;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        bad = 0;
        for (int y = 0; y < SV_ACT; y++) begin
            for (int x = 0; x < SH_ACT; x++) begin
                if (kind == K_SOLID)     e = solid;
                else if (kind == K_BARS) e = bars[x / 8];
                else                     e = ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
                if (pix[y][x] !== e) bad++;
            end
        end
        return bad;
    endfunction

    task automatic check_frame_hygiene(input string tag);
        check({tag, "_de_gaps"}, de_bad, 0);
        check({tag, "_blank"}, blank_bad, 0);
        check({tag, "_fs_count"}, fs_seen, 1);
    endtask

    initial begin
        int n, lines, vs_low, de_cnt, fs_cnt, hd_vs, hd_hs, hd_de;
        logic prev_hs;

        reset_n = 1'b0;
        {mode_s, red_s, green_s, blue_s} = '0;
        {mode_d, red_d, green_d, blue_d} = '0;
        {red_h, green_h, blue_h} = '0;
        mode_h = 2'd3;

        repeat (5) @(negedge clock);
        check("rst_hs", hs_d, 1'b1);
        check("rst_vs", vs_d, 1'b1);
        check("rst_de", de_d, 1'b0);
        check("rst_rgb", rgb_d, 24'h0);
        check("rst_fs", fs_s, 1'b0);
        check("rst_hs_hd", hs_h, 1'b0);
        check("rst_vs_hd", vs_h, 1'b0);

        reset_n = 1'b1;
        @(negedge clock);
        check("first_fs", fs_s, 1'b1);
        check("first_de", de_s, 1'b1);
        check("first_rgb", rgb_s, 24'h0);

        // 640x480 line timing
        wait_edge(0, 1'b0, 2000, n);
        check("hs_sync_wait", n > 0, 1'b1);
        wait_edge(0, 1'b1, 2000, n);
        check("hs_low_width", n, 96);
        wait_edge(0, 1'b0, 2000, n);
        check("hs_period", n + 96, 800);

        // Two frames of vertical timing on the small raster
        wait_edge(2, 1'b0, 2 * S_FRAME, n);
        check("vs_sync_wait", n > 0, 1'b1);
        for (int f = 0; f < 2; f++) begin
            lines = 0; vs_low = 0; de_cnt = 0; fs_cnt = 0;
            prev_hs = hs_s;
            for (int i = 0; i < S_FRAME; i++) begin
                if (i > 0) @(negedge clock);
                if (prev_hs && !hs_s) lines++;
                prev_hs = hs_s;
                if (!vs_s) vs_low++;
                if (de_s)  de_cnt++;
                if (fs_s)  fs_cnt++;
            end
            check("lines_per_frame", lines, SV_TOT);
            check("vs_low_clocks", vs_low, 2 * SH_TOT);
            check("de_clocks", de_cnt, SH_ACT * SV_ACT);
            check("fs_per_frame", fs_cnt, 1);
            wait_edge(2, 1'b0, 10, n);
            check("vs_period", n, 1);
        end

        // Solid magenta
        red_s = 1'b1; green_s = 1'b0; blue_s = 1'b1;
        capture_small(-1, 2'd0);
        check("solid_frame", count_bad(K_SOLID, 24'hFF00FF), 0);
        check("solid_px_0_0", pix[0][0], 24'hFF00FF);
        check("solid_px_63_31", pix[31][63], 24'hFF00FF);
        check_frame_hygiene("solid");

        // Bars requested at frame end: one more solid frame, then bars
        mode_s = 2'd1;
        capture_small(-1, 2'd0);
        check("bars_deferred", count_bad(K_SOLID, 24'hFF00FF), 0);
        capture_small(-1, 2'd0);
        check("bars_frame", count_bad(K_BARS, 24'h0), 0);
        check("bars_px0", pix[0][0], 24'hFFFFFF);
        check("bars_px7", pix[0][7], 24'hFFFFFF);
        check("bars_px8", pix[0][8], 24'hFFFF00);
        check("bars_px20_y10", pix[10][20], 24'h00FFFF);
        check("bars_px56", pix[0][56], 24'h000000);
        check("bars_px63", pix[0][63], 24'h000000);
        check_frame_hygiene("bars");

        mode_s = 2'd0;
        capture_small(-1, 2'd0);
        check("bars_hold", count_bad(K_BARS, 24'h0), 0);

        // Mid-frame switch to checker at line 16 must not tear
        capture_small(16 * SH_TOT, 2'd2);
        check("no_tear_solid", count_bad(K_SOLID, 24'hFF00FF), 0);
        check_frame_hygiene("no_tear");
        capture_small(-1, 2'd0);
        check("checker_frame", count_bad(K_CHECK, 24'h0), 0);
        check("checker_x32", pix[0][32], 24'hFFFFFF);
        check("checker_x0", pix[0][0], 24'h000000);
        check("checker_x31", pix[0][31], 24'h000000);
        check_frame_hygiene("checker");

        // Wide raster, active-high syncs, gradient
        wait_edge(4, 1'b1, HD_FRAME + 10, n);
        check("hd_fs_wait", n > 0, 1'b1);
        hd_vs = 0; hd_hs = 0; hd_de = 0;
        for (int i = 0; i < HD_FRAME; i++) begin
            if (i > 0) @(negedge clock);
            if (i == 3 * HD_H_TOT + 255) check("hd_grad_255_3", rgb_h, 24'hFF03FC);
            if (i == 5 * HD_H_TOT + 300) check("hd_grad_300_5", rgb_h, 24'h2C0529);
            if (vs_h) hd_vs++;
            if (hs_h) hd_hs++;
            if (de_h) hd_de++;
        end
        check("hd_vs_high", hd_vs, HD_H_TOT);
        check("hd_hs_high", hd_hs, 40 * HD_V_TOT);
        check("hd_de_high", hd_de, 1280 * 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
